issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 The clock SHALL be clk_i, input, 1 bit: all state SHALL update on its rising edge.
REQ-002 The reset SHALL be rst_i, input, 1 bit: reset is asynchronous and active-high, and it clears all state.
REQ-003 alloc_i SHALL be an input of 1 bit: the allocator writes an entry this cycle.
REQ-004 alloc_sel_i SHALL be an input of 4 bits: the one-hot entry being allocated.
REQ-005 wakeup_i SHALL be an input of 4 bits: the per-entry signal that all operands are ready.
REQ-006 flush_i SHALL be an input of 1 bit: it discards all entries.
REQ-007 issue_ready_i SHALL be an input of 1 bit: the functional unit accepts an issue.
REQ-008 issue_valid_o SHALL be a registered output of 1 bit: an issue is presented.
REQ-009 issue_sel_o SHALL be a registered output of 4 bits: the one-hot entry presented. It SHALL be 0 when issue_valid_o=0.
REQ-010 resource_valid_o SHALL be an output of 4 bits: the free-entry vector (~busy). It feeds the allocator's resource_valid_i.

Function
REQ-011 The state SHALL be busy[3:0], rdy[3:0], and a 4x4 age matrix old[i][j], where 1 means entry i is older than entry j.
REQ-012 Allocation SHALL occur when alloc_i=1 and alloc_sel_i is exactly one-hot, selecting entry k.
  - A zero or multi-hot alloc_sel_i SHALL be ignored.
  - alloc_sel_i SHALL be ignored when alloc_i=0.
REQ-013 Allocation of entry k SHALL update state as follows:
  - busy[k] set.
  - rdy[k] set to wakeup_i[k].
  - old[j][k] set to busy[j] for all j≠k.
  - old[k][*] cleared.
REQ-014 Allocation to an entry whose busy bit is already set SHALL be ignored, with no state change for that entry.
REQ-015 wakeup_i[i] SHALL set rdy[i] only when busy[i]=1 or entry i is allocated in the same cycle; otherwise it SHALL be ignored.
REQ-016 Entry i SHALL be a candidate when busy[i]=1, rdy[i]=1, and entry i is not the entry currently presented on issue_sel_o.
REQ-017 The pick SHALL be the candidate i for which no other candidate j has old[j][i]=1, i.e. the oldest ready entry; ties are impossible by construction.
REQ-018 A handshake SHALL be defined as issue_valid_o=1 and issue_ready_i=1 at a rising edge.
REQ-019 On a handshake, the presented entry SHALL have busy and rdy cleared at that edge, and its age row and column SHALL be cleared.
REQ-020 The output register SHALL load at an edge when issue_valid_o=0 or a handshake occurs:
  - issue_valid_o set to (any candidate exists).
  - issue_sel_o set to the pick, or 0 if there is none.
REQ-021 Back-to-back issue on consecutive cycles SHALL be supported, giving a throughput of 1 issue per cycle.
REQ-022 While issue_valid_o=1 and issue_ready_i=0, issue_valid_o and issue_sel_o SHALL hold stable, even if an older entry becomes ready.
REQ-023 Latency: an entry that is allocated ready, with the output register empty, SHALL appear on issue_valid_o/issue_sel_o 2 edges after its alloc cycle. The first edge registers the entry; the second edge registers the pick.
REQ-024 resource_valid_o SHALL equal ~busy combinationally from registered state. An entry freed by a handshake SHALL show free from the cycle after the handshake edge.
REQ-025 flush_i=1 at an edge SHALL clear busy, rdy, the age matrix, issue_valid_o and issue_sel_o. flush_i SHALL override alloc_i, wakeup_i and any handshake in the same cycle.
REQ-026 An entry allocated while a handshake on it occurs in the same cycle (illegal from a correct allocator) SHALL end busy, with allocation winning, and SHALL not be re-issued until woken.

Reset
REQ-027 While rst_i=1, the outputs SHALL be: issue_valid_o=0, issue_sel_o=4'b0000, resource_valid_o=4'b1111.
REQ-028 While rst_i=1, all internal state (busy, rdy, age matrix) SHALL be 0.
REQ-029 Reset asserted mid-operation, including during a held handshake, SHALL clear state immediately, with no issue completing.
REQ-030 The first allocation SHALL be accepted at the first rising edge after rst_i deasserts.

Verification
REQ-031 Reset scenario: assert rst_i, then release it -> resource_valid_o=1111, issue_valid_o=0, no issue while idle.
REQ-032 Age-order scenario:
  - Stimulus: allocate entry 0, then 2, then 1 (not ready), with issue_ready_i=0; then wakeup_i=0111.
  - Required response: issue_sel_o=0001 held; then with issue_ready_i=1, 0001, 0100, 0010 on successive cycles.
  - resource_valid_o SHALL return to 1111 after the last issue.
REQ-033 Allocate-with-wakeup scenario: alloc entry 3 with wakeup_i=1000 in the same cycle, issue_ready_i=1 -> issue_valid_o=1 with issue_sel_o=1000 two edges later, and resource_valid_o=1111 one cycle after the handshake.
REQ-034 Backpressure scenario: entry 1 is presented with issue_ready_i=0; an older-ready entry 0 cannot exist, so instead wake entry 2 -> issue_sel_o stays 0010 until issue_ready_i=1, then 0100 follows on the next cycle.
REQ-035 Illegal-input scenario: alloc_sel_i=0110 or 0000 with alloc_i=1, or alloc to a busy entry -> busy is unchanged, and resource_valid_o is unchanged.
REQ-036 Flush scenario:
  - Stimulus: 3 busy entries, one presented, then flush_i=1 together with alloc_i=1, alloc_sel_i=0001.
  - Required response: next cycle resource_valid_o=1111, issue_valid_o=0, issue_sel_o=0000.

Source files
------------

// File: rtl/issue_select_if.sv
// Allocator / functional-unit facing signals of the issue select stage.
// The master side drives allocation, wakeup, flush and ready; the slave side presents issues.
interface issue_select_if;
  logic       alloc_i;
  logic [3:0] alloc_sel_i;
  logic [3:0] wakeup_i;
  logic       flush_i;
  logic       issue_ready_i;
  logic       issue_valid_o;
  logic [3:0] issue_sel_o;
  logic [3:0] resource_valid_o;

  modport master (
    output alloc_i, alloc_sel_i, wakeup_i, flush_i, issue_ready_i,
    input  issue_valid_o, issue_sel_o, resource_valid_o
  );

  modport slave (
    input  alloc_i, alloc_sel_i, wakeup_i, flush_i, issue_ready_i,
    output issue_valid_o, issue_sel_o, resource_valid_o
  );
endinterface

// File: rtl/issue_select.sv
// Four-entry issue queue selector: tracks busy/ready entries and relative age,
// and presents the oldest ready entry through a registered valid/ready output stage.
module issue_select (
  input  logic          clk_i,
  input  logic          rst_i,
  issue_select_if.slave bus
);

  localparam int unsigned N = 4;

  logic [N-1:0]          busy_q, busy_d;
  logic [N-1:0]          rdy_q, rdy_d;
  logic [N-1:0][N-1:0]   old_q, old_d;     // old_q[i][j]: entry i is older than entry j
  logic                  issue_valid_q, issue_valid_d;
  logic [N-1:0]          issue_sel_q, issue_sel_d;

  logic                  alloc_ok;
  logic                  hs;
  logic [N-1:0]          hs_vec;
  logic [N-1:0]          alloc_vec;
  logic [N-1:0]          busy_kept;
  logic [N-1:0]          cand;
  logic [N-1:0]          pick;
  logic                  blocked;

  // Allocation may target the entry retiring at this edge; the allocation wins over the retire.
  always_comb begin
    alloc_ok  = bus.alloc_i && (bus.alloc_sel_i != '0) &&
                ((bus.alloc_sel_i & (bus.alloc_sel_i - 4'd1)) == '0);
    hs        = issue_valid_q & bus.issue_ready_i;
    hs_vec    = hs ? issue_sel_q : '0;
    alloc_vec = alloc_ok ? (bus.alloc_sel_i & (~busy_q | hs_vec)) : '0;
    busy_kept = busy_q & ~hs_vec;
  end

  // The presented entry is excluded so a handshake edge can load the next pick.
  always_comb begin
    cand    = busy_q & rdy_q & ~issue_sel_q;
    pick    = '0;
    blocked = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
        if (cand[j] && old_q[j][i]) begin
          blocked = 1'b1;
        end
      end
      pick[i] = cand[i] & ~blocked;
    end
  end

  always_comb begin
    busy_d        = busy_kept | alloc_vec;
    rdy_d         = (rdy_q & ~hs_vec) | (bus.wakeup_i & busy_kept);
    rdy_d         = (rdy_d & ~alloc_vec) | (bus.wakeup_i & alloc_vec);
    old_d         = old_q;
    issue_valid_d = issue_valid_q;
    issue_sel_d   = issue_sel_q;

    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (hs_vec[i] || hs_vec[j]) begin
          old_d[i][j] = 1'b0;
        end
      end
    end

    for (int unsigned k = 0; k < N; k++) begin
      if (alloc_vec[k]) begin
        for (int unsigned j = 0; j < N; j++) begin
          old_d[k][j] = 1'b0;
          old_d[j][k] = (j != k) && busy_kept[j];
        end
      end
    end

    if (!issue_valid_q || hs) begin
      issue_valid_d = |cand;
      issue_sel_d   = pick;
    end

    if (bus.flush_i) begin
      busy_d        = '0;
      rdy_d         = '0;
      old_d         = '0;
      issue_valid_d = 1'b0;
      issue_sel_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q        <= '0;
      rdy_q         <= '0;
      old_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_sel_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      rdy_q         <= rdy_d;
      old_q         <= old_d;
      issue_valid_q <= issue_valid_d;
      issue_sel_q   <= issue_sel_d;
    end
  end

  assign bus.issue_valid_o    = issue_valid_q;
  assign bus.issue_sel_o      = issue_sel_q;
  assign bus.resource_valid_o = ~busy_q;

endmodule

// File: tb/tb_issue_select.sv
// Scenario bench for issue_select: expected issue order is queued as stimulus is applied
// and popped as the DUT presents entries.
module tb_issue_select;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_sel;

  issue_select_if bus();

  issue_select dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic a, input logic [3:0] s, input logic [3:0] w, input logic r);
    bus.alloc_i       = a;
    bus.alloc_sel_i   = s;
    bus.wakeup_i      = w;
    bus.issue_ready_i = r;
    bus.flush_i       = 1'b0;
  endtask

  task automatic do_flush();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    #1 rst_i = 1'b1;
    #2;
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.issue_valid_o); end
    total++; if (bus.issue_sel_o !== 4'b0000) begin bad++; $display("FAIL rst_sel got=%b want=0000", bus.issue_sel_o); end
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL rst_rv got=%b want=1111", bus.resource_valid_o); end
    step();
    step();
    rst_i = 1'b0;
    drive(1'b1, 4'b0001, 4'b0000, 1'b0);
    step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL rst_first_alloc got=%b want=1110", bus.resource_valid_o); end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=%b want=0", bus.issue_valid_o); end
    end
    do_flush();
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL rst_flush_rv got=%b want=1111", bus.resource_valid_o); end
  endtask

  task automatic test_age_order();
    drive(1'b1, 4'b0001, 4'b0000, 1'b0); step();
    drive(1'b1, 4'b0100, 4'b0000, 1'b0); step();
    drive(1'b1, 4'b0010, 4'b0000, 1'b0); step();
    total++; if (bus.resource_valid_o !== 4'b1000) begin bad++; $display("FAIL age_rv_busy got=%b want=1000", bus.resource_valid_o); end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL age_not_ready got=%b want=0", bus.issue_valid_o); end
    drive(1'b0, 4'b0000, 4'b0111, 1'b0); step();
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); step();
    for (int c = 0; c < 2; c++) begin
      total++; if (bus.issue_sel_o !== 4'b0001 || bus.issue_valid_o !== 1'b1) begin bad++; $display("FAIL age_hold got=%b/%b want=1/0001", bus.issue_valid_o, bus.issue_sel_o); end
      step();
    end
    bus.issue_ready_i = 1'b1;
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      total++;
      if (bus.issue_valid_o !== 1'b1) begin bad++; $display("FAIL age_b2b_valid got=%b want=1", bus.issue_valid_o); end
      else begin
        exp_sel = exp_q.pop_front();
        if (bus.issue_sel_o !== exp_sel) begin bad++; $display("FAIL age_order got=%b want=%b", bus.issue_sel_o, exp_sel); end
      end
      step();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL age_drain got=%0d left want=0", exp_q.size()); exp_q.delete(); end
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL age_rv_free got=%b want=1111", bus.resource_valid_o); end
    total++; if (bus.issue_valid_o !== 1'b0 || bus.issue_sel_o !== 4'b0000) begin bad++; $display("FAIL age_idle got=%b/%b want=0/0000", bus.issue_valid_o, bus.issue_sel_o); end
    bus.issue_ready_i = 1'b0;
  endtask

  task automatic test_alloc_wakeup();
    drive(1'b1, 4'b1000, 4'b1000, 1'b1);
    exp_q.push_back(4'b1000);
    step();
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL aw_edge1 got=%b want=0", bus.issue_valid_o); end
    total++; if (bus.resource_valid_o !== 4'b0111) begin bad++; $display("FAIL aw_rv_busy got=%b want=0111", bus.resource_valid_o); end
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    step();
    total++;
    if (bus.issue_valid_o !== 1'b1) begin bad++; $display("FAIL aw_edge2_valid got=%b want=1", bus.issue_valid_o); end
    else begin
      exp_sel = exp_q.pop_front();
      if (bus.issue_sel_o !== exp_sel) begin bad++; $display("FAIL aw_edge2_sel got=%b want=%b", bus.issue_sel_o, exp_sel); end
    end
    exp_q.delete();
    step();
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL aw_rv_free got=%b want=1111", bus.resource_valid_o); end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL aw_after got=%b want=0", bus.issue_valid_o); end
    bus.issue_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'b0010, 4'b0010, 1'b0); step();
    drive(1'b1, 4'b0100, 4'b0000, 1'b0); step();
    exp_q.push_back(4'b0010);
    total++; if (bus.issue_valid_o !== 1'b1 || bus.issue_sel_o !== 4'b0010) begin bad++; $display("FAIL bp_present got=%b/%b want=1/0010", bus.issue_valid_o, bus.issue_sel_o); end
    drive(1'b0, 4'b0000, 4'b0100, 1'b0); step();
    exp_q.push_back(4'b0100);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.issue_valid_o !== 1'b1 || bus.issue_sel_o !== 4'b0010) begin bad++; $display("FAIL bp_hold got=%b/%b want=1/0010", bus.issue_valid_o, bus.issue_sel_o); end
      step();
    end
    bus.issue_ready_i = 1'b1;
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      total++;
      if (bus.issue_valid_o !== 1'b1) begin bad++; $display("FAIL bp_b2b_valid got=%b want=1", bus.issue_valid_o); end
      else begin
        exp_sel = exp_q.pop_front();
        if (bus.issue_sel_o !== exp_sel) begin bad++; $display("FAIL bp_order got=%b want=%b", bus.issue_sel_o, exp_sel); end
      end
      step();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d left want=0", exp_q.size()); exp_q.delete(); end
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL bp_rv_free got=%b want=1111", bus.resource_valid_o); end
    bus.issue_ready_i = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'b0001, 4'b0000, 1'b0); step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL ill_base got=%b want=1110", bus.resource_valid_o); end
    drive(1'b1, 4'b0110, 4'b0000, 1'b0); step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL ill_multihot got=%b want=1110", bus.resource_valid_o); end
    drive(1'b1, 4'b0000, 4'b0000, 1'b0); step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL ill_zero got=%b want=1110", bus.resource_valid_o); end
    drive(1'b0, 4'b0010, 4'b0000, 1'b0); step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL ill_no_alloc got=%b want=1110", bus.resource_valid_o); end
    drive(1'b1, 4'b0001, 4'b0000, 1'b0); step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL ill_busy got=%b want=1110", bus.resource_valid_o); end
    drive(1'b0, 4'b0000, 4'b0010, 1'b0); step();
    drive(1'b1, 4'b0010, 4'b0000, 1'b0); step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); step(); step();
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL ill_stray_wakeup got=%b want=0", bus.issue_valid_o); end
    total++; if (bus.resource_valid_o !== 4'b1100) begin bad++; $display("FAIL ill_rv_two got=%b want=1100", bus.resource_valid_o); end
    do_flush();
  endtask

  task automatic test_flush();
    drive(1'b1, 4'b0001, 4'b0001, 1'b0); step();
    drive(1'b1, 4'b0010, 4'b0000, 1'b0); step();
    drive(1'b1, 4'b0100, 4'b0000, 1'b0); step();
    total++; if (bus.issue_valid_o !== 1'b1 || bus.issue_sel_o !== 4'b0001) begin bad++; $display("FAIL fl_present got=%b/%b want=1/0001", bus.issue_valid_o, bus.issue_sel_o); end
    drive(1'b1, 4'b0001, 4'b0001, 1'b1);
    bus.flush_i = 1'b1;
    step();
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL fl_rv got=%b want=1111", bus.resource_valid_o); end
    total++; if (bus.issue_valid_o !== 1'b0 || bus.issue_sel_o !== 4'b0000) begin bad++; $display("FAIL fl_out got=%b/%b want=0/0000", bus.issue_valid_o, bus.issue_sel_o); end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); step();
    total++; if (bus.issue_valid_o !== 1'b0 || bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL fl_after got=%b/%b want=0/1111", bus.issue_valid_o, bus.resource_valid_o); end
  endtask

  task automatic test_hs_alloc_same();
    drive(1'b1, 4'b0001, 4'b0001, 1'b0); step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); step();
    total++; if (bus.issue_valid_o !== 1'b1 || bus.issue_sel_o !== 4'b0001) begin bad++; $display("FAIL hsa_present got=%b/%b want=1/0001", bus.issue_valid_o, bus.issue_sel_o); end
    drive(1'b1, 4'b0001, 4'b0000, 1'b1); step();
    total++; if (bus.resource_valid_o !== 4'b1110) begin bad++; $display("FAIL hsa_busy got=%b want=1110", bus.resource_valid_o); end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL hsa_no_reissue got=%b want=0", bus.issue_valid_o); end
    drive(1'b0, 4'b0000, 4'b0000, 1'b1); step();
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL hsa_sleep got=%b want=0", bus.issue_valid_o); end
    drive(1'b0, 4'b0000, 4'b0001, 1'b0); step();
    exp_q.push_back(4'b0001);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); step();
    total++;
    if (bus.issue_valid_o !== 1'b1) begin bad++; $display("FAIL hsa_woken_valid got=%b want=1", bus.issue_valid_o); end
    else begin
      exp_sel = exp_q.pop_front();
      if (bus.issue_sel_o !== exp_sel) begin bad++; $display("FAIL hsa_woken_sel got=%b want=%b", bus.issue_sel_o, exp_sel); end
    end
    exp_q.delete();
    bus.issue_ready_i = 1'b1; step();
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL hsa_free got=%b want=1111", bus.resource_valid_o); end
    bus.issue_ready_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 4'b1000, 4'b1000, 1'b0); step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); step();
    total++; if (bus.issue_valid_o !== 1'b1 || bus.issue_sel_o !== 4'b1000) begin bad++; $display("FAIL mr_present got=%b/%b want=1/1000", bus.issue_valid_o, bus.issue_sel_o); end
    bus.issue_ready_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    total++; if (bus.issue_valid_o !== 1'b0 || bus.issue_sel_o !== 4'b0000) begin bad++; $display("FAIL mr_async got=%b/%b want=0/0000", bus.issue_valid_o, bus.issue_sel_o); end
    total++; if (bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL mr_rv got=%b want=1111", bus.resource_valid_o); end
    step();
    rst_i = 1'b0;
    step();
    total++; if (bus.issue_valid_o !== 1'b0 || bus.resource_valid_o !== 4'b1111) begin bad++; $display("FAIL mr_after got=%b/%b want=0/1111", bus.issue_valid_o, bus.resource_valid_o); end
    bus.issue_ready_i = 1'b0;
  endtask

  initial begin
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    test_reset();
    test_age_order();
    test_alloc_wakeup();
    test_backpressure();
    test_illegal();
    test_flush();
    test_hs_alloc_same();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
